// File: rtl/seq_mult_arb_pkg.sv
// Shared types, default widths and helpers for the sequential multiplier arbiter.
package seq_mult_arb_pkg;

  localparam int unsigned DEF_A_W = 16;
  localparam int unsigned DEF_B_W = 16;
  localparam int unsigned DEF_Z_W = 33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Index width able to address n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [IDX_W-1:0]   o_idx_c
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Scan requesters in rotated order starting from the pointer
  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_gnt_c[w_cand] = 1'b1;
        o_idx_c         = w_cand;
      end
    end
  end

endmodule

// File: rtl/seq_mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier between NUM_REQ requesters,
// with a watchdog that turns a silent multiplier into an error response.
module seq_mult_arbiter
  import seq_mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned Z_W     = DEF_Z_W,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDX_W  = idx_w(NUM_REQ)
) (
  input  logic                   sig_clk,
  input  logic                   sig_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [Z_W-1:0]         rsp_z,
  output logic                   rsp_err,
  output logic [A_W-1:0]         sig_a,
  output logic [B_W-1:0]         sig_b,
  output logic                   sig_ab_valid,
  input  logic                   sig_ab_ready,
  input  logic [Z_W-1:0]         sig_z,
  input  logic                   sig_z_valid,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner_id
);

  localparam int unsigned WD_W = idx_w(TIMEOUT);

  state_e               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]     r_owner, w_owner_nxt;
  logic [A_W-1:0]       r_a, w_a_nxt;
  logic [B_W-1:0]       r_b, w_b_nxt;
  logic [Z_W-1:0]       r_z, w_z_nxt;
  logic                 r_err, w_err_nxt;
  logic [WD_W-1:0]      r_wd, w_wd_nxt;
  logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
  logic                 r_ab_valid, w_ab_valid_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_gnt_idx)
  );

  // Accept pulse only while idle; the grant itself is the acceptance
  assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;

  // State register
  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state plus next values of every registered datapath/output bit
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_z_nxt      = r_z;
    w_err_nxt    = r_err;
    w_wd_nxt     = r_wd;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_state_nxt  = ST_ISSUE;
          w_owner_nxt  = w_gnt_idx;
          w_a_nxt      = req_a[32'(w_gnt_idx) * A_W +: A_W];
          w_b_nxt      = req_b[32'(w_gnt_idx) * B_W +: B_W];
          w_rr_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
        end
      end
      ST_ISSUE: begin
        if (sig_ab_ready) begin
          w_state_nxt = ST_WAIT;
          w_wd_nxt    = '0;
        end
      end
      ST_WAIT: begin
        w_wd_nxt = r_wd + WD_W'(1);
        // A strobe arriving on the last allowed cycle still beats the timeout
        if (sig_z_valid) begin
          w_z_nxt     = sig_z;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (r_wd == WD_W'(TIMEOUT - 2)) begin
          w_z_nxt     = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[r_owner]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_ab_valid_nxt  = (w_state_nxt == ST_ISSUE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_rsp_valid_nxt = '0;
    if (w_state_nxt == ST_RESP) w_rsp_valid_nxt[w_owner_nxt] = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_z         <= '0;
      r_err       <= 1'b0;
      r_wd        <= '0;
      r_rsp_valid <= '0;
      r_ab_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_z         <= w_z_nxt;
      r_err       <= w_err_nxt;
      r_wd        <= w_wd_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_ab_valid  <= w_ab_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_z        = r_z;
  assign rsp_err      = r_err;
  assign sig_a        = r_a;
  assign sig_b        = r_b;
  assign sig_ab_valid = r_ab_valid;
  assign busy         = r_busy;
  assign owner_id     = r_owner;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Directed bench for seq_mult_arbiter with a response scoreboard and a simple multiplier model.
module tb_seq_mult_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int ZW = 33;
  localparam int TO = 64;

  logic              sig_clk = 1'b0;
  logic              sig_rst_n = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic [ZW-1:0]     rsp_z, sig_z;
  logic              rsp_err;
  logic [AW-1:0]     sig_a;
  logic [BW-1:0]     sig_b;
  logic              sig_ab_valid, sig_ab_ready, sig_z_valid, busy;
  logic [1:0]        owner_id;

  typedef struct packed {
    logic [1:0]    idx;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [ZW-1:0] z;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  seq_mult_arbiter #(
    .NUM_REQ (NR), .A_W (AW), .B_W (BW), .Z_W (ZW), .TIMEOUT (TO)
  ) dut (
    .sig_clk      (sig_clk),
    .sig_rst_n    (sig_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_z        (rsp_z),
    .rsp_err      (rsp_err),
    .sig_a        (sig_a),
    .sig_b        (sig_b),
    .sig_ab_valid (sig_ab_valid),
    .sig_ab_ready (sig_ab_ready),
    .sig_z        (sig_z),
    .sig_z_valid  (sig_z_valid),
    .busy         (busy),
    .owner_id     (owner_id)
  );

  always #5 sig_clk = ~sig_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sig_clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_valid[i]        = 1'b1;
    req_a[i*AW +: AW]   = a;
    req_b[i*BW +: BW]   = b;
  endtask

  // Wait for the accept pulse, record the expected response, land in the ISSUE cycle
  task automatic grant(input int exp_idx, input bit never, input string tag);
    int   k;
    exp_t e;
    k = 0;
    #1;
    while (req_ready == '0 && k < 16) begin
      tick(); #1; k++;
    end
    check({tag, "_req_ready"}, 64'(req_ready), 64'(1) << exp_idx);
    e.idx = 2'(exp_idx);
    e.a   = req_a[exp_idx*AW +: AW];
    e.b   = req_b[exp_idx*BW +: BW];
    e.z   = never ? '0 : 33'(e.a) * 33'(e.b);
    e.err = never;
    sb.push_back(e);
    tick();
    check({tag, "_issue_valid"}, 64'(sig_ab_valid), 64'(1));
    check({tag, "_owner"}, 64'(owner_id), 64'(exp_idx));
    check({tag, "_sig_a"}, 64'(sig_a), 64'(e.a));
    check({tag, "_sig_b"}, 64'(sig_b), 64'(e.b));
    check({tag, "_no_ready_busy"}, 64'(req_ready), 64'(0));
  endtask

  // Multiplier model: optional operand stall, then strobe sig_a*sig_b or stay silent
  task automatic mult(input int ab_wait, input int z_wait, input bit never, input string tag);
    int lat;
    for (int k = 0; k < ab_wait; k++) begin
      check({tag, "_stall_valid"}, 64'(sig_ab_valid), 64'(1));
      check({tag, "_stall_a"}, 64'(sig_a), 64'(sb[sb.size()-1].a));
      check({tag, "_stall_b"}, 64'(sig_b), 64'(sb[sb.size()-1].b));
      tick();
    end
    sig_ab_ready = 1'b1;
    tick();
    sig_ab_ready = 1'b0;
    check({tag, "_valid_dropped"}, 64'(sig_ab_valid), 64'(0));
    if (never) begin
      lat = 1;
      while (rsp_valid == '0 && lat < TO + 8) begin
        tick(); lat++;
      end
      check({tag, "_timeout_latency"}, 64'(lat), 64'(TO));
    end else begin
      for (int k = 0; k < z_wait; k++) tick();
      sig_z       = 33'(sig_a) * 33'(sig_b);
      sig_z_valid = 1'b1;
      tick();
      sig_z_valid = 1'b0;
      sig_z       = 33'h1_5A5A_5A5A;
    end
  endtask

  // Observe the response, optionally hold off rsp_ready with spurious non-owner readies
  task automatic respond(input int exp_lat, input int hold, input logic [NR-1:0] spurious,
                         input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (rsp_valid == '0 && k < TO + 8) begin
      tick(); k++;
    end
    if (exp_lat >= 0) check({tag, "_rsp_latency"}, 64'(k), 64'(exp_lat));
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard: observed empty queue, expected a pending entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1) << e.idx);
      check({tag, "_rsp_z"}, 64'(rsp_z), 64'(e.z));
      check({tag, "_rsp_err"}, 64'(rsp_err), 64'(e.err));
      for (int h = 0; h < hold; h++) begin
        rsp_ready = spurious;
        tick();
        check({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1) << e.idx);
        check({tag, "_hold_z"}, 64'(rsp_z), 64'(e.z));
        check({tag, "_hold_no_grant"}, 64'(req_ready), 64'(0));
      end
      rsp_ready        = '0;
      rsp_ready[e.idx] = 1'b1;
      tick();
      rsp_ready = '0;
      check({tag, "_rsp_done"}, 64'(rsp_valid), 64'(0));
      check({tag, "_idle"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    req_valid    = '0;
    rsp_ready    = '0;
    req_a        = '0;
    req_b        = '0;
    sig_ab_ready = 1'b0;
    sig_z_valid  = 1'b0;
    sig_z        = 33'h1_5A5A_5A5A;

    // Reset values
    tick(); tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_ab_valid", 64'(sig_ab_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp_z", 64'(rsp_z), 64'(0));
    sig_rst_n = 1'b1;
    tick();

    // All requesters valid, zero-wait multiplier: grant order 0,1,2,3,0
    set_req(0, 16'h1234, 16'h0002);
    set_req(1, 16'hFFFF, 16'hFFFF);
    set_req(2, 16'h00FF, 16'h0100);
    set_req(3, 16'h8000, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      grant(order[i], 1'b0, "rr");
      mult(0, 0, 1'b0, "rr");
      if (i == 4) req_valid = '0;
      respond(0, 0, '0, "rr");
    end

    // Single requester 2, 3*5 with a slow strobe
    set_req(2, 16'h0003, 16'h0005);
    grant(2, 1'b0, "single");
    req_valid[2] = 1'b0;
    mult(0, 4, 1'b0, "single");
    respond(0, 0, '0, "single");

    // Multiplier stalls operand acceptance for 10 cycles
    set_req(0, 16'hABCD, 16'h1357);
    grant(0, 1'b0, "stall");
    req_valid[0] = 1'b0;
    mult(10, 2, 1'b0, "stall");
    respond(0, 0, '0, "stall");

    // Multiplier never answers: error response, then a late strobe while idle
    set_req(1, 16'h0007, 16'h0009);
    grant(1, 1'b1, "timeout");
    req_valid[1] = 1'b0;
    mult(0, 0, 1'b1, "timeout");
    respond(0, 0, '0, "timeout");
    sig_z       = 33'h1_2345_6789;
    sig_z_valid = 1'b1;
    tick();
    sig_z_valid = 1'b0;
    tick();
    check("late_strobe_z", 64'(rsp_z), 64'(0));
    check("late_strobe_busy", 64'(busy), 64'(0));
    check("late_strobe_rsp", 64'(rsp_valid), 64'(0));

    // Response backpressure with other requesters pending and non-owner readies
    set_req(3, 16'h0100, 16'h0100);
    grant(3, 1'b0, "bp");
    req_valid[3] = 1'b0;
    set_req(0, 16'h0011, 16'h0022);
    set_req(1, 16'h0033, 16'h0044);
    set_req(2, 16'h0055, 16'h0066);
    mult(0, 1, 1'b0, "bp");
    respond(0, 20, 4'b0111, "bp");
    grant(0, 1'b0, "bp_next");
    req_valid = '0;
    mult(0, 0, 1'b0, "bp_next");
    respond(0, 0, '0, "bp_next");

    // Reset while waiting on the multiplier
    set_req(1, 16'hBEEF, 16'h0011);
    grant(1, 1'b0, "mid_rst");
    req_valid    = '0;
    sig_ab_ready = 1'b1;
    tick();
    sig_ab_ready = 1'b0;
    #2 sig_rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_ab_valid", 64'(sig_ab_valid), 64'(0));
    check("mid_rst_sig_a", 64'(sig_a), 64'(0));
    check("mid_rst_sig_b", 64'(sig_b), 64'(0));
    check("mid_rst_rsp_z", 64'(rsp_z), 64'(0));
    check("mid_rst_err", 64'(rsp_err), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_owner", 64'(owner_id), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    sb.delete();
    tick();
    sig_rst_n = 1'b1;
    set_req(0, 16'h0002, 16'h0003);
    set_req(1, 16'h0004, 16'h0005);
    set_req(2, 16'h0006, 16'h0007);
    set_req(3, 16'h0008, 16'h0009);
    grant(0, 1'b0, "post_rst");
    req_valid = '0;
    mult(0, 0, 1'b0, "post_rst");
    respond(0, 0, '0, "post_rst");

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult_arbiter.md
# seq_mult_arbiter

Round-robin scheduler that shares one sequential multiplier (16x16 operands, 33-bit result, valid/ready operand handshake, single-cycle result strobe) between NUM_REQ requesters. It accepts one operand pair at a time, sequences it into the multiplier, captures the result strobe, and returns the result to the owning requester with its own valid/ready handshake. A watchdog converts a multiplier that never answers into an error response.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- A_W, 16, operand A width
- B_W, 16, operand B width
- Z_W, 33, result width
- TIMEOUT, 64, max cycles waiting for sig_z_valid before error (>=2)

Ports:
- sig_clk  in  1  single clock, all logic rising-edge
- sig_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept pulse (one-hot or zero)
- req_a  in  NUM_REQ*A_W  packed operands A, requester i at [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed operands B
- rsp_valid  out  NUM_REQ  one-hot response valid to owning requester
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_z  out  Z_W  result (shared bus, qualified by rsp_valid)
- rsp_err  out  1  1 = timeout, rsp_z is 0
- sig_a  out  A_W  operand A to multiplier
- sig_b  out  B_W  operand B to multiplier
- sig_ab_valid  out  1  operand valid to multiplier
- sig_ab_ready  in  1  multiplier accepts operands
- sig_z  in  Z_W  multiplier result
- sig_z_valid  in  1  one-cycle result strobe, no backpressure
- busy  out  1  state != IDLE
- owner_id  out  $clog2(NUM_REQ)  requester currently served

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, rr pick winner starting at rr_ptr; pulse req_ready[winner] this cycle, latch req_a/req_b slice and owner_id; go ISSUE. rr_ptr <= winner+1 (wraps NUM_REQ-1 -> 0).
- ISSUE: sig_ab_valid=1, sig_a/sig_b = latched operands, held stable; on sig_ab_valid & sig_ab_ready go WAIT, clear watchdog.
- WAIT: watchdog increments each cycle; on sig_z_valid latch sig_z into rsp_z, rsp_err=0, go RESP. If watchdog reaches TIMEOUT-1 without strobe: rsp_z=0, rsp_err=1, go RESP. Strobe and timeout same cycle: strobe wins.
- RESP: rsp_valid[owner_id]=1, rsp_z/rsp_err stable; on rsp_ready[owner_id] go IDLE. rsp_ready of other requesters ignored.
- sig_z_valid outside WAIT ignored (no state change, no capture).
- Only one operation outstanding; req_ready never asserted outside IDLE.
- Result passed unmodified; no sign handling in this block.

## Timing
- Reset (async assert, sync-safe deassert assumed at top): state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_z 0, rsp_err 0, sig_a 0, sig_b 0, sig_ab_valid 0, busy 0, owner_id 0, watchdog 0. Reset mid-operation drops the transaction silently.
- Request accepted cycle T (req_valid & req_ready) -> sig_ab_valid high from T+1.
- Multiplier strobe at cycle S -> rsp_valid high from S+1.
- Minimum turnaround: response accepted cycle R -> next req_ready earliest R+1.
- Zero-wait multiplier path: request at T, sig_ab_ready at T+1, strobe at T+2 -> rsp_valid at T+3.
- Timeout: rsp_valid with rsp_err exactly TIMEOUT cycles after the ISSUE handshake cycle.
- All outputs registered except req_ready (combinational from IDLE, req_valid, rr_ptr).

## Structure
- Package seq_mult_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default widths A_W/B_W/Z_W, idx width function.
- Sub-module rr_arbiter: NUM_REQ request vector + rr_ptr in, one-hot grant + grant index out, purely combinational; pointer register stays in seq_mult_arbiter.

## Test plan
- Single requester 2: a=0x0003, b=0x0005, multiplier strobes sig_z=15 after 4 cycles -> req_ready[2] one pulse, rsp_valid=0b0100, rsp_z=15, rsp_err=0.
- All 4 requesters valid continuously, instant multiplier -> grant order 0,1,2,3,0 with rr_ptr wrap; each rsp to correct index, a=0xFFFF,b=0xFFFF gives rsp_z=0x0FFFE0001.
- sig_ab_ready held low 10 cycles -> sig_ab_valid, sig_a, sig_b stable all 10 cycles; watchdog not running.
- Multiplier never strobes, TIMEOUT=64 -> rsp_err=1, rsp_z=0 exactly 64 cycles after ISSUE handshake; late strobe in IDLE ignored.
- rsp_ready held low 20 cycles, other requesters valid -> no req_ready pulses, rsp held; spurious rsp_ready on non-owner ignored.
- sig_rst_n asserted in WAIT -> all outputs 0 immediately; after release first grant goes to requester 0.
